// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-in / parallel-out deserializer: the receive side of the narrow-beat
// serializer link. BEATS beats of IN_W bits from a valid/ready stream are
// assembled into one OUT_W-bit word, which is presented on a registered
// valid/ready output stream. The design sustains one beat per cycle with no
// bubbles; only the final beat of a word can be stalled by output backpressure.
//
// Optional build macro: SIPO_LAST_CHECK_EN
//   defined   : the `last_i` marker is checked on every accepted beat; a
//               mismatch raises a one-cycle err_o pulse. An early `last`
//               discards the partial word; a missing `last` still emits it.
//   undefined : `last_i` is ignored, framing is by beat count only, err_o = 0.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous reset, active-high
//   din_valid_i   serial beat present
//   din_data_i    serial beat payload (IN_W)
//   din_ready_o   beat accepted when din_valid_i & din_ready_o
//   last_i        qualifies din; high on the final beat of a word
//   dout_valid_o  assembled word present
//   dout_data_o   assembled word (OUT_W)
//   dout_ready_i  word consumed when dout_valid_o & dout_ready_i
//   err_o         one-cycle framing-error pulse
// -----------------------------------------------------------------------------
module sipo_deser #(
    parameter int unsigned IN_W      = 2,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             din_valid_i,
    input  logic [IN_W-1:0]  din_data_i,
    output logic             din_ready_o,
    input  logic             last_i,
    output logic             dout_valid_o,
    output logic [OUT_W-1:0] dout_data_o,
    input  logic             dout_ready_i,
    output logic             err_o
);

    localparam int unsigned BEATS = OUT_W / IN_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [OUT_W-1:0] acc_q,        acc_d;
    logic             dout_valid_q, dout_valid_d;
    logic [OUT_W-1:0] dout_data_q,  dout_data_d;
    logic             err_q,        err_d;

    logic             final_s;
    logic             din_ready_s;
    logic             accept_s;
    logic             frame_err_s;
    logic             early_last_s;
    logic [OUT_W-1:0] word_s;

    // Bit offset of the accumulator slot that beat number `c` lands in.
    function automatic int unsigned slot_lo(input logic [CNT_W-1:0] c);
        if (MSB_FIRST) begin
            slot_lo = (BEATS - 1 - int'(c)) * IN_W;
        end else begin
            slot_lo = int'(c) * IN_W;
        end
    endfunction

`ifdef SIPO_LAST_CHECK_EN
    // A `last` on a non-final beat, or no `last` on the final beat, is a
    // framing error; only the early-last case abandons the partial word.
    assign frame_err_s  = accept_s & (last_i ^ final_s);
    assign early_last_s = accept_s & last_i & ~final_s;
`else
    logic unused_last_s;
    assign unused_last_s = last_i;
    assign frame_err_s   = 1'b0;
    assign early_last_s  = 1'b0;
`endif

    // State register: beat counter, accumulator and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            err_q        <= err_d;
        end
    end

    // Input handshake: the final beat waits until the output register is free
    // or being drained in the same cycle, which gives back-to-back words.
    always_comb begin
        final_s     = (cnt_q == LAST_CNT);
        din_ready_s = 1'b0;
        if (rst_i) begin
            din_ready_s = 1'b0;
        end else if (!final_s) begin
            din_ready_s = 1'b1;
        end else begin
            din_ready_s = ~dout_valid_q | dout_ready_i;
        end
        accept_s = din_valid_i & din_ready_s;
        // Accumulator contents with the current beat dropped into its slot.
        word_s = acc_q;
        word_s[slot_lo(cnt_q) +: IN_W] = din_data_i;
    end

    // Next-state logic for the collector and the output register.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        err_d        = frame_err_s;

        if (accept_s && final_s) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (early_last_s) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept_s) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = word_s;
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end

        // A completed word wins over a drain so a consume and a load in the
        // same cycle keep dout valid; dout data is left alone when draining.
        if (accept_s && final_s) begin
            dout_valid_d = 1'b1;
            dout_data_d  = word_s;
        end else if (dout_ready_i) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // Output drive.
    always_comb begin
        din_ready_o  = din_ready_s;
        dout_valid_o = dout_valid_q;
        dout_data_o  = dout_data_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    localparam int IN_W  = 2;
    localparam int OUT_W = 8;
    localparam int BEATS = OUT_W / IN_W;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             din_valid_i;
    logic [IN_W-1:0]  din_data_i;
    logic             din_ready_o;
    logic             last_i;
    logic             dout_valid_o;
    logic [OUT_W-1:0] dout_data_o;
    logic             dout_ready_i;
    logic             err_o;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    bit started = 1'b0;

    // model state
    int unsigned     beats_q[$];
    logic [OUT_W-1:0] exp_q[$];
    bit              err_pend = 1'b0;
    bit              hold_prev = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;

    sipo_deser #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .din_valid_i  (din_valid_i),
        .din_data_i   (din_data_i),
        .din_ready_o  (din_ready_o),
        .last_i       (last_i),
        .dout_valid_o (dout_valid_o),
        .dout_data_o  (dout_data_o),
        .dout_ready_i (dout_ready_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
        int k;
        din_valid_i = 1'b1;
        din_data_i  = d;
        last_i      = l;
        #0;
        k = 0;
        while (!din_ready_o && k < 50) begin
            step();
            stalls++;
            k++;
        end
        if (k >= 50) chk("send_timeout", 32'(k), 32'd0);
        step();
    endtask

    task automatic send_word(input logic [OUT_W-1:0] w);
        for (int i = 0; i < BEATS; i++) begin
            send_beat(w[OUT_W-1-IN_W*i -: IN_W], i == BEATS - 1);
        end
    endtask

    // Scoreboard: collects accepted beats MSB-first into words, tracks the
    // expected error pulse, and checks output stability under backpressure.
    always @(negedge clk_i) begin
        if (started) begin
            if (rst_i) begin
                beats_q.delete();
                exp_q.delete();
                err_pend  = 1'b0;
                hold_prev = 1'b0;
            end else begin
                logic [31:0] w;
                chk("err", 32'(err_o), 32'(err_pend));
                if (hold_prev) begin
                    chk("hold_valid", 32'(dout_valid_o), 32'd1);
                    chk("hold_data", 32'(dout_data_o), 32'(prev_data));
                end
                if (dout_valid_o && dout_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(dout_data_o), 32'hFFFF_FFFF);
                    end else begin
                        chk("word", 32'(dout_data_o), 32'(exp_q.pop_front()));
                    end
                end
                err_pend = 1'b0;
                if (din_valid_i && din_ready_o) begin
`ifdef SIPO_LAST_CHECK_EN
                    if (last_i && beats_q.size() != BEATS - 1) begin
                        beats_q.delete();
                        err_pend = 1'b1;
                    end else begin
                        beats_q.push_back(32'(din_data_i));
                        if (beats_q.size() == BEATS) err_pend = !last_i;
                    end
`else
                    beats_q.push_back(32'(din_data_i));
`endif
                    if (beats_q.size() == BEATS) begin
                        w = 0;
                        foreach (beats_q[i]) w = (w << IN_W) | beats_q[i];
                        exp_q.push_back(w[OUT_W-1:0]);
                        beats_q.delete();
                    end
                end
                hold_prev = dout_valid_o && !dout_ready_i;
                prev_data = dout_data_o;
            end
        end
    end

    initial begin
        rst_i        = 1'b1;
        din_valid_i  = 1'b0;
        din_data_i   = '0;
        last_i       = 1'b0;
        dout_ready_i = 1'b1;
        step();
        step();
        started = 1'b1;
        // reset state
        chk("rst_din_ready", 32'(din_ready_o), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid_o), 32'd0);
        chk("rst_dout_data", 32'(dout_data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rel_din_ready", 32'(din_ready_o), 32'd1);

        // single word 0xCD, valid one cycle after the 4th beat
        send_word(8'hCD);
        chk("t1_valid", 32'(dout_valid_o), 32'd1);
        chk("t1_data", 32'(dout_data_o), 32'hCD);
        din_valid_i = 1'b0;
        step();
        chk("t1_valid_drop", 32'(dout_valid_o), 32'd0);
        chk("t1_data_keep", 32'(dout_data_o), 32'hCD);

        // continuous stream 0xCD then 0x27 without ready drops
        stalls = 0;
        send_word(8'hCD);
        chk("t2_w0", 32'(dout_data_o), 32'hCD);
        send_word(8'h27);
        chk("t2_w1_valid", 32'(dout_valid_o), 32'd1);
        chk("t2_w1", 32'(dout_data_o), 32'h27);
        chk("t2_stalls", 32'(stalls), 32'd0);
        din_valid_i = 1'b0;
        step();

        // backpressure stalls only the final beat
        dout_ready_i = 1'b0;
        send_word(8'hCD);
        chk("t3_held", 32'(dout_data_o), 32'hCD);
        stalls = 0;
        send_beat(2'b00, 1'b0);
        send_beat(2'b10, 1'b0);
        send_beat(2'b01, 1'b0);
        chk("t3_stalls", 32'(stalls), 32'd0);
        din_valid_i = 1'b1;
        din_data_i  = 2'b11;
        last_i      = 1'b1;
        #0;
        chk("t3_ready_low", 32'(din_ready_o), 32'd0);
        step();
        step();
        chk("t3_ready_low2", 32'(din_ready_o), 32'd0);
        chk("t3_valid_held", 32'(dout_valid_o), 32'd1);
        chk("t3_data_held", 32'(dout_data_o), 32'hCD);
        dout_ready_i = 1'b1;
        #1;
        chk("t3_ready_back", 32'(din_ready_o), 32'd1);
        step();
        chk("t3_b2b_valid", 32'(dout_valid_o), 32'd1);
        chk("t3_b2b_data", 32'(dout_data_o), 32'h27);
        din_valid_i = 1'b0;
        step();
        chk("t3_drain", 32'(dout_valid_o), 32'd0);

        // reset mid-word discards the partial beats
        send_beat(2'b11, 1'b0);
        send_beat(2'b00, 1'b0);
        din_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        chk("t4_rst_valid", 32'(dout_valid_o), 32'd0);
        chk("t4_rst_data", 32'(dout_data_o), 32'd0);
        chk("t4_rst_ready", 32'(din_ready_o), 32'd0);
        rst_i = 1'b0;
        send_word(8'hAD);
        chk("t4_valid", 32'(dout_valid_o), 32'd1);
        chk("t4_data", 32'(dout_data_o), 32'hAD);
        din_valid_i = 1'b0;
        step();

        // gapped input
        for (int i = 0; i < BEATS; i++) begin
            if (i > 0) begin
                din_valid_i = 1'b0;
                step();
                chk("t5_no_early", 32'(dout_valid_o), 32'd0);
            end
            send_beat(((i == 0) || (i == 1)) ? 2'b10 : ((i == 2) ? 2'b11 : 2'b01), i == BEATS - 1);
        end
        chk("t5_valid", 32'(dout_valid_o), 32'd1);
        chk("t5_data", 32'(dout_data_o), 32'hAD);
        din_valid_i = 1'b0;
        step();
        chk("t5_drop", 32'(dout_valid_o), 32'd0);

`ifdef SIPO_LAST_CHECK_EN
        // early last: error pulse, no word, then a clean word
        send_beat(2'b11, 1'b0);
        send_beat(2'b00, 1'b1);
        chk("t6_err", 32'(err_o), 32'd1);
        din_valid_i = 1'b0;
        step();
        chk("t6_err_pulse", 32'(err_o), 32'd0);
        chk("t6_no_word", 32'(dout_valid_o), 32'd0);
        send_word(8'hCD);
        chk("t6_valid", 32'(dout_valid_o), 32'd1);
        chk("t6_data", 32'(dout_data_o), 32'hCD);
        chk("t6_err_clean", 32'(err_o), 32'd0);
`else
        // misplaced last is ignored: framing by beat count only
        send_beat(2'b11, 1'b0);
        send_beat(2'b00, 1'b1);
        send_beat(2'b11, 1'b0);
        send_beat(2'b01, 1'b0);
        chk("t6_valid", 32'(dout_valid_o), 32'd1);
        chk("t6_data", 32'(dout_data_o), 32'hCD);
        chk("t6_err", 32'(err_o), 32'd0);
`endif
        din_valid_i = 1'b0;
        step();
        step();
        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
